uart_receiver: RTL and testbench



---
 rtl/uart_pkg.sv | 15 +
 rtl/sync_2ff.sv | 24 ++
 rtl/uart_receiver.sv | 160 ++++++++++++++++
 tb/tb_uart_receiver.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART register-path receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_e;

    localparam int UART_CLKS_PER_BIT_DEF = 16;
    localparam int UART_IDLE_BITS_DEF    = 32;
    localparam int UART_ADDR_W           = 4;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous level; resets to 1 (idle line).
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 oversampling receiver with auto-incrementing 4-bit address, reset by line-idle gaps.
// Stop-bit checking and frame_err are enabled by defining UART_FRAME_CHECK_EN.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF,
    parameter int IDLE_BITS    = UART_IDLE_BITS_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rx,
    output logic [UART_ADDR_W-1:0] uart_addr,
    output logic [7:0]             uart_data,
    output logic                   uart_ready,
    output logic                   frame_err
);

    localparam int BIT_CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int IDLE_MAX   = IDLE_BITS * CLKS_PER_BIT;
    localparam int IDLE_CNT_W = $clog2(IDLE_MAX + 1);

    localparam logic [BIT_CNT_W-1:0]  HALF_M1    = BIT_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_CNT_W-1:0]  FULL_M1    = BIT_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDLE_CNT_W-1:0] IDLE_MAX_C = IDLE_CNT_W'(IDLE_MAX);

    logic                   rx_s;
    logic                   rx_prev_q;
    uart_state_e            state_q,     state_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q,   bit_cnt_d;
    logic [2:0]             bit_idx_q,   bit_idx_d;
    logic [7:0]             shift_q,     shift_d;
    logic [IDLE_CNT_W-1:0]  idle_cnt_q,  idle_cnt_d;
    logic [UART_ADDR_W-1:0] next_addr_q, next_addr_d;
    logic [UART_ADDR_W-1:0] addr_q,      addr_d;
    logic [7:0]             data_q,      data_d;
    logic                   ready_q,     ready_d;
    logic                   ferr_q,      ferr_d;
    logic                   commit;

    sync_2ff u_rx_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (rx),
        .q_o   (rx_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_prev_q   <= 1'b1;
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            idle_cnt_q  <= '0;
            next_addr_q <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            ready_q     <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            rx_prev_q   <= rx_s;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            idle_cnt_q  <= idle_cnt_d;
            next_addr_q <= next_addr_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            ready_q     <= ready_d;
            ferr_q      <= ferr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        idle_cnt_d  = idle_cnt_q;
        next_addr_d = next_addr_q;
        addr_d      = addr_q;
        data_d      = data_q;
        ready_d     = ready_q;
        ferr_d      = 1'b0;
        commit      = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Edge detect needs a high previous sample, so after a low stop bit
                // the line must return high before a new frame is accepted.
                if (rx_prev_q && !rx_s) begin
                    state_d   = START;
                    bit_cnt_d = '0;
                end else if (rx_s && idle_cnt_q != IDLE_MAX_C) begin
                    idle_cnt_d = idle_cnt_q + IDLE_CNT_W'(1);
                end
                if (idle_cnt_q == IDLE_MAX_C) begin
                    next_addr_d = '0;
                end
            end
            START: begin
                if (bit_cnt_q == HALF_M1) begin
                    bit_cnt_d  = '0;
                    idle_cnt_d = '0;
                    if (!rx_s) begin
                        ready_d   = 1'b0;
                        bit_idx_d = '0;
                        state_d   = DATA;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_cnt_q == FULL_M1) begin
                    bit_cnt_d = '0;
                    shift_d   = {rx_s, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                end
            end
            STOP: begin
                if (bit_cnt_q == FULL_M1) begin
                    bit_cnt_d = '0;
                    state_d   = IDLE;
`ifdef UART_FRAME_CHECK_EN
                    commit = rx_s;
                    ferr_d = !rx_s;
`else
                    commit = 1'b1;
`endif
                end else begin
                    bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (commit) begin
            data_d      = shift_q;
            addr_d      = next_addr_q;
            next_addr_d = next_addr_q + UART_ADDR_W'(1);
            ready_d     = 1'b1;
        end
    end

    assign uart_addr  = addr_q;
    assign uart_data  = data_q;
    assign uart_ready = ready_q;
    assign frame_err  = ferr_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: expected {addr,data} pushed per frame, popped on uart_ready rise.
module tb_uart_receiver;

    localparam int CPB   = 16;
    localparam int IBITS = 32;

    typedef struct packed {
        logic [3:0] addr;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic [3:0] uart_addr;
    logic [7:0] uart_data;
    logic       uart_ready;
    logic       frame_err;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         n_push  = 0;
    int         n_rise  = 0;
    int         n_ferr  = 0;
    int         snap;
    exp_t       sb_q[$];
    exp_t       mon_e;
    logic       rdy_prev = 1'b0;
    logic [3:0] exp_addr = 4'd0;

    uart_receiver #(.CLKS_PER_BIT(CPB), .IDLE_BITS(IBITS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .uart_addr  (uart_addr),
        .uart_data  (uart_data),
        .uart_ready (uart_ready),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (uart_ready && !rdy_prev) begin
                n_rise++;
                if (sb_q.size() == 0) begin
                    chk("unexpected_ready", 32'd1, 32'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("addr", 32'(uart_addr), 32'(mon_e.addr));
                    chk("data", 32'(uart_data), 32'(mon_e.data));
                end
            end
            if (frame_err) n_ferr++;
        end
        rdy_prev = uart_ready;
    end

    task automatic send_bit(input logic b);
        rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
    endtask

    task automatic send_byte(input logic [7:0] d);
        sb_q.push_back({exp_addr, d});
        n_push++;
        exp_addr = exp_addr + 4'd1;
        send_frame(d, 1'b1);
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * CPB) @(negedge clk);
        if (n >= IBITS) exp_addr = 4'd0;
    endtask

    initial begin
        rx    = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_addr",  32'(uart_addr),  32'd0);
        chk("rst_data",  32'(uart_data),  32'd0);
        chk("rst_ready", 32'(uart_ready), 32'd0);
        chk("rst_ferr",  32'(frame_err),  32'd0);
        rst_n = 1'b1;
        idle_bits(2);

        send_byte(8'hA5);
        idle_bits(2);
        chk("a5_ferr", 32'(n_ferr), 32'd0);

        // 17 back-to-back bytes: addresses 0..15 then wrap to 0
        idle_bits(IBITS + 1);
        for (int i = 0; i < 17; i++) send_byte(8'((i + 1) * 17));
        idle_bits(1);
        chk("b2b_rises", 32'(n_rise), 32'(n_push));

        idle_bits(IBITS + 1);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        idle_bits(IBITS);
        send_byte(8'h7E);
        send_byte(8'h04); send_byte(8'h05);
        idle_bits(IBITS - 1);
        send_byte(8'h7E);
        idle_bits(2);

        chk("pre_glitch_rdy", 32'(uart_ready), 32'd1);
        snap = n_rise;
        rx = 1'b0;
        repeat (CPB / 4) @(negedge clk);
        idle_bits(2);
        chk("glitch_rdy",  32'(uart_ready), 32'd1);
        chk("glitch_rise", 32'(n_rise), 32'(snap));
        send_byte(8'h96);
        idle_bits(1);

`ifdef UART_FRAME_CHECK_EN
        snap = n_ferr;
        send_frame(8'h3C, 1'b0);
        idle_bits(2);
        chk("ferr_pulse", 32'(n_ferr - snap), 32'd1);
        chk("ferr_ready", 32'(uart_ready), 32'd0);
        chk("ferr_data",  32'(uart_data),  32'h96);
        chk("ferr_addr",  32'(uart_addr),  32'd4);
`else
        sb_q.push_back({exp_addr, 8'h3C});
        n_push++;
        exp_addr = exp_addr + 4'd1;
        send_frame(8'h3C, 1'b0);
        idle_bits(2);
        chk("nochk_ready", 32'(uart_ready), 32'd1);
        chk("nochk_data",  32'(uart_data),  32'h3C);
`endif
        send_byte(8'hC3);
        idle_bits(2);

        // Reset asserted in the middle of data bit 4
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        rx = 1'b1;
        repeat (CPB / 2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_addr",  32'(uart_addr),  32'd0);
        chk("midrst_data",  32'(uart_data),  32'd0);
        chk("midrst_ready", 32'(uart_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_addr = 4'd0;
        idle_bits(2);
        send_byte(8'h5A);
        idle_bits(2);

        for (int i = 0; i < 2000 && sb_q.size() != 0; i++) @(negedge clk);
        chk("sb_empty",   32'(sb_q.size()), 32'd0);
        chk("rise_total", 32'(n_rise), 32'(n_push));
`ifdef UART_FRAME_CHECK_EN
        chk("ferr_total", 32'(n_ferr), 32'd1);
`else
        chk("ferr_total", 32'(n_ferr), 32'd0);
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
